// File: rtl/cdc_ctrl_pkg.sv
// Shared types and constants for the source-side mux-ndff CDC transfer controller.
package cdc_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDrop = 2'd2
  } xfer_state_e;

  localparam int unsigned SyncStages = 2;

endpackage

// File: rtl/cdc_mux_xfer_ctrl_rr_arb.sv
// Round-robin arbiter: picks the first set request searching upward (wrapping) from ptr+1.
module rr_arb #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(NREQ);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/cdc_mux_xfer_ctrl.sv
// Source-domain controller for a shared mux-ndff CDC channel: round-robin arbitration
// plus a four-phase tx_en/ack handshake with tx_data frozen for the whole handshake.
module cdc_mux_xfer_ctrl
  import cdc_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*DW-1:0]      req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [DW-1:0]           tx_data_o,
  output logic                    tx_en_o,
  input  logic                    ack_async_i,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] grant_id_o,
  output logic                    done_o,
  output logic [CW-1:0]           xfer_cnt_o
);

  localparam int unsigned IdxW = $clog2(NREQ);

  xfer_state_e     state_q, state_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            tx_en_q, tx_en_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [SyncStages-1:0] ack_sync_q;
  logic                  ack_sync;

  logic [NREQ-1:0] arb_grant;
  logic [IdxW-1:0] arb_idx;

  rr_arb #(
    .NREQ(NREQ)
  ) u_rr_arb (
    .req_i  (req_valid_i),
    .ptr_i  (ptr_q),
    .grant_o(arb_grant),
    .idx_o  (arb_idx)
  );

  // ack_async only ever reaches logic through this synchronizer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SyncStages-2:0], ack_async_i};
    end
  end

  assign ack_sync = ack_sync_q[SyncStages-1];

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_en_d     = tx_en_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    case (state_q)
      StIdle: begin
        if (|req_valid_i) begin
          req_ready_o = arb_grant;
          tx_data_d   = req_data_i[32'(arb_idx) * DW +: DW];
          tx_en_d     = 1'b1;
          grant_d     = arb_idx;
          ptr_d       = arb_idx;
          state_d     = StReq;
        end
      end
      StReq: begin
        // An ack already high on entry is simply taken as the ack.
        if (ack_sync) begin
          tx_en_d = 1'b0;
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (!ack_sync) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      grant_q   <= '0;
      ptr_q     <= IdxW'(NREQ - 1);
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_en_o    = tx_en_q;
  assign grant_id_o = grant_q;
  assign done_o     = done_q;
  assign xfer_cnt_o = cnt_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_cdc_mux_xfer_ctrl.sv
// Self-checking bench for cdc_mux_xfer_ctrl (NREQ=4, DW=8, CW=4) using an expected-grant scoreboard.
module tb_cdc_mux_xfer_ctrl;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 4;

  logic             clk;
  logic             rstn;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic [DW-1:0]    tx_data;
  logic             tx_en;
  logic             ack_async;
  logic             busy;
  logic [1:0]       grant_id;
  logic             done;
  logic [CW-1:0]    xfer_cnt;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   exp_ptr   = 3;
  int   exp_cnt   = 0;
  int   done_seen = 0;
  int   overlap   = 0;
  int   done_base = 0;

  cdc_mux_xfer_ctrl #(
    .NREQ(NREQ),
    .DW  (DW),
    .CW  (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_ready_o(req_ready),
    .tx_data_o  (tx_data),
    .tx_en_o    (tx_en),
    .ack_async_i(ack_async),
    .busy_o     (busy),
    .grant_id_o (grant_id),
    .done_o     (done),
    .xfer_cnt_o (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn) begin
      if (done) done_seen++;
      if (done && tx_en) overlap++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int i = 1; i <= 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return 0;
  endfunction

  // Called while the DUT is in IDLE with req_valid already driven for this cycle.
  task automatic xfer(input bit hold, input bit scramble, input int ack_dly);
    int   g;
    int   n;
    exp_t e;
    exp_t got_e;
    #1;
    g = rr_pick(req_valid, exp_ptr);
    check_eq("req_ready", 32'(req_ready), 32'(4'b0001 << g));
    e.id   = g;
    e.data = req_data[g*8 +: 8];
    sb.push_back(e);
    exp_ptr = g;
    @(negedge clk);
    if (!hold) req_valid[g] = 1'b0;
    check_eq("tx_en_rise", 32'(tx_en), 32'd1);
    check_eq("busy_req", 32'(busy), 32'd1);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
      return;
    end
    got_e = sb.pop_front();
    check_eq("grant_id", 32'(grant_id), 32'(got_e.id));
    check_eq("tx_data", 32'(tx_data), 32'(got_e.data));
    if (scramble) req_data[g*8 +: 8] = ~got_e.data;
    repeat (ack_dly) @(negedge clk);
    ack_async = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check_eq("tx_data_hold_req", 32'(tx_data), 32'(got_e.data));
    end while (tx_en && n < 10);
    check_eq("ack_to_txen_fall", 32'(n), 32'd3);
    check_eq("busy_drop", 32'(busy), 32'd1);
    ack_async = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check_eq("tx_data_hold_drop", 32'(tx_data), 32'(got_e.data));
    end while (!done && n < 10);
    check_eq("done_latency", 32'(n), 32'd3);
    exp_cnt = (exp_cnt + 1) % 16;
    check_eq("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    check_eq("txen_low_at_done", 32'(tx_en), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    ack_async = 1'b0;
    #1;
    check_eq("rst_tx_en", 32'(tx_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check_eq("idle_no_ready", 32'(req_ready), 32'd0);
    check_eq("idle_no_busy", 32'(busy), 32'd0);

    // Single transfer from requester 0.
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    xfer(1'b0, 1'b0, 3);
    @(negedge clk);
    check_eq("stay_idle", 32'(busy), 32'd0);

    // Data stability: requester 0 changes its word mid-handshake.
    req_data[7:0] = 8'h5A;
    req_valid     = 4'b0001;
    xfer(1'b0, 1'b1, 2);
    @(negedge clk);

    // Reset mid-transfer while in REQ.
    req_data[23:16] = 8'h77;
    req_valid       = 4'b0100;
    #1;
    check_eq("rst_case_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    check_eq("rst_case_in_req", 32'(tx_en), 32'd1);
    ack_async = 1'b1;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check_eq("abort_tx_en", 32'(tx_en), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_grant_id", 32'(grant_id), 32'd0);
    check_eq("abort_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check_eq("abort_tx_data", 32'(tx_data), 32'd0);
    ack_async = 1'b0;
    req_valid = '0;
    sb.delete();
    exp_ptr   = 3;
    exp_cnt   = 0;
    done_base = done_seen;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Round-robin, back-to-back, and counter wrap: 17 transfers with all four requesting.
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      xfer(1'b1, 1'b0, i % 4);
      if (i < 16) check_eq("b2b_ready_with_done", 32'(req_ready != 0 && done), 32'd1);
    end
    req_valid = '0;
    @(negedge clk);
    check_eq("wrap_xfer_cnt", 32'(xfer_cnt), 32'd1);
    check_eq("done_count", 32'(done_seen - done_base), 32'd17);
    check_eq("done_txen_overlap", 32'(overlap), 32'd0);
    check_eq("final_idle", 32'(busy), 32'd0);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdc_mux_xfer_ctrl.md
Name: cdc_mux_xfer_ctrl

Overview:
- Source-domain (clk) controller for a shared mux-ndff CDC channel. It arbitrates round-robin among NREQ requesters and drives one channel data word, tx_data, plus a level enable, tx_en, across to the destination domain.
- It runs a four-phase handshake. The destination's synchronized enable comes back as ack_async; the controller holds tx_data stable from tx_en assertion until ack has returned low.
- It sits beside the destination-side mux-ndff capture block. One instance serves each clock-crossing channel.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 8, data word width.
- CW, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  source-domain clock.
- rstn  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NREQ  per-requester request; the requester holds it and its data until the matching req_ready.
- req_data  input  NREQ*DW  packed request words; requester i occupies bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant/accept pulse, combinational, asserted only in IDLE.
- tx_data  output  DW  registered data to the destination domain.
- tx_en  output  1  registered level enable to the destination domain.
- ack_async  input  1  destination's synchronized enable; asynchronous to clk.
- busy  output  1  high whenever state is not IDLE.
- grant_id  output  $clog2(NREQ)  index of the requester owning the current transfer; holds its last value in IDLE.
- done  output  1  one-cycle pulse when a transfer fully completes.
- xfer_cnt  output  CW  count of completed transfers; wraps at 2^CW.

Behaviour:
- Reset values: tx_data=0, tx_en=0, busy=0, grant_id=0, done=0, xfer_cnt=0, state=IDLE, ack synchronizer flops=0, rr pointer=NREQ-1 (so req 0 has first priority).
- ack_async goes through a 2-flop synchronizer to ack_sync. Only ack_sync is used; ack_async never feeds logic directly.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise g = first set bit searching upward (wrapping) from ptr+1.
  - Same cycle: req_ready[g]=1.
  - Next edge: tx_data<=req_data[g], tx_en<=1, grant_id<=g, ptr<=g, state->REQ.
- REQ:
  - tx_en=1 and tx_data frozen.
  - When ack_sync==1, at the next edge: tx_en<=0, state->DROP.
- DROP:
  - tx_en=0 and tx_data still frozen.
  - When ack_sync==0, at the next edge: done<=1 for one cycle, xfer_cnt<=xfer_cnt+1, state->IDLE.
- IDLE may grant in the cycle after entering it. The done pulse and the next req_ready can therefore coincide.
- Latency: req_valid seen in IDLE at edge n gives tx_en high after edge n+1. ack_async rising between edges k-1 and k gives ack_sync high after edge k+1, and tx_en low after edge k+2.
- tx_data changes only on the IDLE->REQ edge. It is never modified while tx_en=1 or ack_sync=1.
- Simultaneous requests: exactly one grant per IDLE cycle. Rotating priority means no requester waits more than NREQ-1 transfers.
- A requester dropping req_valid in IDLE before it is granted is legal; the request is simply not taken.
- ack_sync already high on entering REQ (protocol violation): treat it as an immediate ack.
- ack_sync never returning: the controller stays in REQ or DROP indefinitely. There is no timeout; upper-level monitoring handles it.
- rstn asserted mid-transfer: all state returns to reset values immediately. tx_en dropping is how the destination sees the abort; it must tolerate a truncated handshake.
- xfer_cnt wraps from 2^CW-1 to 0 without a flag.

Decomposition:
- Shared package cdc_ctrl_pkg:
  - state enum {IDLE, REQ, DROP} (2 bits);
  - SYNC_STAGES=2.
- Natural sub-module rr_arb (NREQ): inputs req and ptr, outputs onehot grant and grant index.
- The ack synchronizer reuses the team's existing ndff macro.

Test Plan:
- Single transfer, NREQ=4, DW=8:
  - req_valid=0001, req_data[0]=8'hA5 -> req_ready[0] pulses.
  - Next cycle: tx_en=1, tx_data=A5.
  - Bench acks 3 cycles later -> tx_en falls 2–3 edges after ack_async.
  - Bench drops ack -> done pulses; xfer_cnt=1.
- Round-robin with all four requesting continuously (data 8'h10,11,12,13) -> grant order 0,1,2,3,0, and tx_data sequence matches.
- Data stability: requester 0 changes req_data[0] after grant while REQ/DROP is active -> tx_data stays at the original value until done.
- Reset mid-transfer:
  - rstn low while in REQ -> tx_en=0, busy=0, grant_id=0, xfer_cnt=0 asynchronously.
  - After release, next grant goes to requester 0.
- Counter wrap with CW=4: 17 transfers -> xfer_cnt reads 1.
  - done asserted exactly 17 times.
  - No overlap between done and tx_en of the same transfer.
- Back-to-back: a pending request in the cycle done pulses -> req_ready asserts in the first IDLE cycle and tx_en rises the following edge.
